// File: rtl/btnctrl_pixel_fetch_if.sv
// rtl/btnctrl_pixel_fetch_if.sv - read-only SRAM bus between pixel fetch and screen SRAM
//   sram_en   : read enable, driven by the fetch side
//   sram_addr : read address, driven by the fetch side
//   sram_data : registered read data, one cycle after sram_addr
interface btnctrl_pixel_fetch_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16
);
  logic                  sram_en;
  logic [ADDR_WIDTH-1:0] sram_addr;
  logic [DATA_WIDTH-1:0] sram_data;

  modport master (output sram_en, output sram_addr, input sram_data);
  modport slave  (input sram_en, input sram_addr, output sram_data);
endinterface

// File: rtl/btnctrl_pixel_fetch.sv
// rtl/btnctrl_pixel_fetch.sv - 2x-scaled RGB332 window fetch, RGB444 composite and blink FSM
//   clk, reset_n          : pixel clock, asynchronous active-low reset
//   pixel_x/pixel_y       : current VGA coordinate
//   video_on              : visible-area flag
//   frame_tick, blink_req : start-of-frame pulse, blink request pulse
//   bg_rgb                : background colour aligned with pixel_x/y
//   sram                  : SRAM read bus (master side)
//   rgb_o/rgb_valid       : composited pixel, video_on delayed 3 cycles
//   sprite_hit            : opaque image pixel drawn
//   blink_busy            : blink sequence in progress
module btnctrl_pixel_fetch #(
  parameter int                  DATA_WIDTH   = 8,
  parameter int                  ADDR_WIDTH   = 16,
  parameter int                  IMG_W        = 160,
  parameter int                  IMG_H        = 120,
  parameter int                  ORG_X        = 160,
  parameter int                  ORG_Y        = 120,
  parameter logic [DATA_WIDTH-1:0] TRANSPARENT = 8'hE3,
  parameter int                  BLINK_FRAMES = 8,
  parameter int                  BLINK_COUNT  = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [9:0]            pixel_x,
  input  logic [9:0]            pixel_y,
  input  logic                  video_on,
  input  logic                  frame_tick,
  input  logic                  blink_req,
  input  logic [11:0]           bg_rgb,
  btnctrl_pixel_fetch_if.master sram,
  output logic [11:0]           rgb_o,
  output logic                  rgb_valid,
  output logic                  sprite_hit,
  output logic                  blink_busy
);

  localparam logic [9:0] X_LO = 10'(ORG_X);
  localparam logic [9:0] X_HI = 10'(ORG_X + 2 * IMG_W);
  localparam logic [9:0] Y_LO = 10'(ORG_Y);
  localparam logic [9:0] Y_HI = 10'(ORG_Y + 2 * IMG_H);
  localparam int FW = (BLINK_FRAMES < 2) ? 1 : $clog2(BLINK_FRAMES + 1);
  localparam int PW = (BLINK_COUNT  < 2) ? 1 : $clog2(BLINK_COUNT + 1);

  // ---------------- stage 1: window test and address ----------------
  logic                  in_win;
  logic [9:0]            dx_half, dy_half;
  logic [ADDR_WIDTH-1:0] addr_calc;

  assign in_win = video_on && (pixel_x >= X_LO) && (pixel_x < X_HI)
                           && (pixel_y >= Y_LO) && (pixel_y < Y_HI);
  // Each source pixel covers a 2x2 screen block, so drop the LSB of the offset.
  assign dx_half   = (pixel_x - X_LO) >> 1;
  assign dy_half   = (pixel_y - Y_LO) >> 1;
  assign addr_calc = ADDR_WIDTH'(dy_half) * ADDR_WIDTH'(IMG_W) + ADDR_WIDTH'(dx_half);

  logic        win1, von1, win2, von2;
  logic [11:0] bg1, bg2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sram.sram_en   <= 1'b0;
      sram.sram_addr <= '0;
      win1           <= 1'b0;
      von1           <= 1'b0;
      bg1            <= '0;
    end else begin
      sram.sram_en <= in_win;
      // Holding the address outside the window avoids needless SRAM toggling.
      if (in_win) sram.sram_addr <= addr_calc;
      win1 <= in_win;
      von1 <= video_on;
      bg1  <= bg_rgb;
    end
  end

  // ---------------- stage 2: SRAM read in flight ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      win2 <= 1'b0;
      von2 <= 1'b0;
      bg2  <= '0;
    end else begin
      win2 <= win1;
      von2 <= von1;
      bg2  <= bg1;
    end
  end

  // ---------------- blink FSM ----------------
  typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF} blink_state_t;

  blink_state_t  state, state_nxt;
  logic [FW-1:0] frame_cnt, frame_nxt;
  logic [PW-1:0] pair_cnt, pair_nxt, pair_inc;
  logic          frame_last;
  logic          blink_inv;

  assign frame_last = (frame_cnt == FW'(BLINK_FRAMES - 1));
  assign pair_inc   = pair_cnt + PW'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      frame_cnt <= '0;
      pair_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      frame_cnt <= frame_nxt;
      pair_cnt  <= pair_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    frame_nxt = frame_cnt;
    pair_nxt  = pair_cnt;
    case (state)
      S_IDLE: begin
        // A frame_tick coinciding with the request is deliberately not counted.
        if (blink_req) begin
          state_nxt = S_ON;
          frame_nxt = '0;
          pair_nxt  = '0;
        end
      end
      S_ON: begin
        if (frame_tick) begin
          if (frame_last) begin
            state_nxt = S_OFF;
            frame_nxt = '0;
          end else begin
            frame_nxt = frame_cnt + FW'(1);
          end
        end
      end
      S_OFF: begin
        if (frame_tick) begin
          if (frame_last) begin
            frame_nxt = '0;
            pair_nxt  = pair_inc;
            state_nxt = (pair_inc == PW'(BLINK_COUNT)) ? S_IDLE : S_ON;
          end else begin
            frame_nxt = frame_cnt + FW'(1);
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    blink_busy = (state != S_IDLE);
    blink_inv  = (state == S_ON);
  end

  // ---------------- stage 3: expand and composite ----------------
  logic [DATA_WIDTH-1:0] d;
  logic [11:0]           img, img_x;
  logic                  opaque;

  assign d      = sram.sram_data;
  // Replicate the MSBs so full-scale RGB332 maps to full-scale RGB444.
  assign img    = {d[7:5], d[7], d[4:2], d[4], d[1:0], d[1:0]};
  assign img_x  = blink_inv ? (img ^ 12'hFFF) : img;
  assign opaque = win2 && (d != TRANSPARENT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rgb_o      <= '0;
      rgb_valid  <= 1'b0;
      sprite_hit <= 1'b0;
    end else begin
      rgb_valid  <= von2;
      sprite_hit <= opaque;
      if (!von2)       rgb_o <= '0;
      else if (opaque) rgb_o <= img_x;
      else             rgb_o <= bg2;
    end
  end

endmodule

// File: tb/tb_btnctrl_pixel_fetch.sv
// tb/tb_btnctrl_pixel_fetch.sv - self-checking bench for btnctrl_pixel_fetch
module tb_btnctrl_pixel_fetch;

  localparam int OX = 160, OY = 120, IW = 160, IH = 120;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [9:0]  pixel_x, pixel_y;
  logic        video_on, frame_tick, blink_req;
  logic [11:0] bg_rgb;
  logic [11:0] rgb_o;
  logic        rgb_valid, sprite_hit, blink_busy;

  always #5 clk = ~clk;

  btnctrl_pixel_fetch_if #(.DATA_WIDTH(8), .ADDR_WIDTH(16)) sram_bus ();

  btnctrl_pixel_fetch #(.BLINK_FRAMES(2), .BLINK_COUNT(2)) dut (
    .clk(clk), .reset_n(reset_n), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .video_on(video_on), .frame_tick(frame_tick), .blink_req(blink_req),
    .bg_rgb(bg_rgb), .sram(sram_bus), .rgb_o(rgb_o), .rgb_valid(rgb_valid),
    .sprite_hit(sprite_hit), .blink_busy(blink_busy)
  );

  // Screen SRAM: 1-cycle registered read.
  logic [7:0] mem [0:65535];
  always @(posedge clk) if (sram_bus.sram_en) sram_bus.sram_data <= mem[sram_bus.sram_addr];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int x, input int y, input logic von, input logic [11:0] bg,
                       input logic ft, input logic br);
    pixel_x = 10'(x); pixel_y = 10'(y); video_on = von; bg_rgb = bg;
    frame_tick = ft; blink_req = br;
  endtask

  // Reference model: plain arithmetic on the spec's rules.
  function automatic logic [11:0] expand(input logic [7:0] d);
    int r3, g3, b2;
    r3 = d / 32; g3 = (d / 4) % 8; b2 = d % 4;
    return 12'((r3 * 2 + r3 / 4) * 256 + (g3 * 2 + g3 / 4) * 16 + b2 * 5);
  endfunction

  function automatic bit m_win(input int x, input int y, input logic von);
    return von && x >= OX && x < OX + 2 * IW && y >= OY && y < OY + 2 * IH;
  endfunction

  function automatic logic [15:0] m_addr(input int x, input int y);
    return 16'(((y - OY) / 2) * IW + (x - OX) / 2);
  endfunction

  typedef struct {
    logic [9:0] x, y; logic von; logic [11:0] bg; logic wr; logic [7:0] d;
    logic en; logic [15:0] addr; logic [11:0] rgb; logic hit;
  } vec_t;
  vec_t tbl [10];

  logic        e_en  [0:399];
  logic [15:0] e_addr[0:399];
  logic [11:0] e_rgb [0:399];
  logic        e_hit [0:399];
  logic        e_von [0:399];

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = ($urandom_range(0, 3) == 0) ? 8'hE3 : 8'($urandom);
    drive(0, 0, 1'b0, 12'h000, 1'b0, 1'b0);
    sram_bus.sram_data = 8'h00;

    // ---- reset state ----
    reset_n = 1'b0;
    repeat (3) step();
    chk("rst_sram_en", 32'(sram_bus.sram_en), 0);
    chk("rst_sram_addr", 32'(sram_bus.sram_addr), 0);
    chk("rst_rgb_o", 32'(rgb_o), 0);
    chk("rst_rgb_valid", 32'(rgb_valid), 0);
    chk("rst_sprite_hit", 32'(sprite_hit), 0);
    chk("rst_blink_busy", 32'(blink_busy), 0);
    reset_n = 1'b1;
    step();

    // ---- table-driven vectors ----
    tbl[0] = '{x:10'd160, y:10'd120, von:1'b1, bg:12'h000, wr:1'b1, d:8'h49, en:1'b1, addr:16'd0,     rgb:12'h445, hit:1'b1};
    tbl[1] = '{x:10'd161, y:10'd121, von:1'b1, bg:12'h000, wr:1'b1, d:8'h49, en:1'b1, addr:16'd0,     rgb:12'h445, hit:1'b1};
    tbl[2] = '{x:10'd320, y:10'd120, von:1'b1, bg:12'h0A0, wr:1'b1, d:8'hE3, en:1'b1, addr:16'd80,    rgb:12'h0A0, hit:1'b0};
    tbl[3] = '{x:10'd479, y:10'd359, von:1'b1, bg:12'h000, wr:1'b1, d:8'hFF, en:1'b1, addr:16'd19199, rgb:12'hFFF, hit:1'b1};
    tbl[4] = '{x:10'd159, y:10'd120, von:1'b1, bg:12'h123, wr:1'b0, d:8'h00, en:1'b0, addr:16'd19199, rgb:12'h123, hit:1'b0};
    tbl[5] = '{x:10'd480, y:10'd200, von:1'b1, bg:12'h123, wr:1'b0, d:8'h00, en:1'b0, addr:16'd19199, rgb:12'h123, hit:1'b0};
    tbl[6] = '{x:10'd200, y:10'd130, von:1'b0, bg:12'h123, wr:1'b0, d:8'h00, en:1'b0, addr:16'd19199, rgb:12'h000, hit:1'b0};
    tbl[7] = '{x:10'd200, y:10'd130, von:1'b1, bg:12'h0A0, wr:1'b1, d:8'h00, en:1'b1, addr:16'd820,   rgb:12'h000, hit:1'b1};
    tbl[8] = '{x:10'd160, y:10'd359, von:1'b1, bg:12'h000, wr:1'b1, d:8'h1C, en:1'b1, addr:16'd19040, rgb:12'h0F0, hit:1'b1};
    tbl[9] = '{x:10'd200, y:10'd360, von:1'b1, bg:12'h456, wr:1'b0, d:8'h00, en:1'b0, addr:16'd19040, rgb:12'h456, hit:1'b0};
    for (int i = 0; i < 10; i++) begin
      if (tbl[i].wr) mem[tbl[i].addr] = tbl[i].d;
      drive(int'(tbl[i].x), int'(tbl[i].y), tbl[i].von, tbl[i].bg, 1'b0, 1'b0);
      step();
      chk($sformatf("vec%0d_sram_en", i), 32'(sram_bus.sram_en), 32'(tbl[i].en));
      chk($sformatf("vec%0d_sram_addr", i), 32'(sram_bus.sram_addr), 32'(tbl[i].addr));
      step();
      step();
      chk($sformatf("vec%0d_rgb_o", i), 32'(rgb_o), 32'(tbl[i].rgb));
      chk($sformatf("vec%0d_sprite_hit", i), 32'(sprite_hit), 32'(tbl[i].hit));
      chk($sformatf("vec%0d_rgb_valid", i), 32'(rgb_valid), 32'(tbl[i].von));
    end

    // ---- randomized pixels against the reference model (blink idle) ----
    begin
      logic [15:0] maddr;
      maddr = tbl[9].addr;
      for (int i = 0; i < 400; i++) begin
        int x, y;
        logic von, w;
        logic [11:0] bg;
        logic [7:0] d;
        x = 150 + $urandom_range(0, 340);
        y = 110 + $urandom_range(0, 260);
        von = ($urandom_range(0, 4) != 0);
        bg = 12'($urandom);
        w = m_win(x, y, von);
        if (w) maddr = m_addr(x, y);
        d = mem[maddr];
        e_en[i]   = w;
        e_addr[i] = maddr;
        e_von[i]  = von;
        e_hit[i]  = w && (d != 8'hE3);
        e_rgb[i]  = !von ? 12'h000 : e_hit[i] ? expand(d) : bg;
        drive(x, y, von, bg, 1'($urandom), 1'b0);
        step();
        chk("rnd_sram_en", 32'(sram_bus.sram_en), 32'(e_en[i]));
        chk("rnd_sram_addr", 32'(sram_bus.sram_addr), 32'(e_addr[i]));
        if (i >= 2) begin
          chk("rnd_rgb_o", 32'(rgb_o), 32'(e_rgb[i-2]));
          chk("rnd_sprite_hit", 32'(sprite_hit), 32'(e_hit[i-2]));
          chk("rnd_rgb_valid", 32'(rgb_valid), 32'(e_von[i-2]));
        end
      end
    end

    // ---- blink sequence: 2 frames per phase, 2 ON/OFF pairs ----
    mem[m_addr(200, 200)] = 8'h49;
    drive(200, 200, 1'b1, 12'h000, 1'b0, 1'b0);
    repeat (4) step();
    begin
      bit active, inv_old;
      int k;
      active = 0; k = 0;
      for (int c = 0; c < 36; c++) begin
        logic ft, br;
        ft = (c == 0) || (c % 3 == 0);
        br = (c == 0) || (c == 14);
        inv_old = active && ((k / 2) % 2 == 0);
        if (!active && br) begin
          active = 1; k = 0;
        end else if (active && ft) begin
          k++;
          if (k == 8) active = 0;
        end
        drive(200, 200, 1'b1, 12'h000, ft, br);
        step();
        chk($sformatf("blink_busy_c%0d", c), 32'(blink_busy), 32'(active));
        chk($sformatf("blink_rgb_c%0d", c), 32'(rgb_o), inv_old ? 32'h0BBA : 32'h0445);
      end
    end

    // ---- reset during BLINK_ON ----
    drive(200, 200, 1'b1, 12'h000, 1'b0, 1'b1);
    step();
    drive(200, 200, 1'b1, 12'h000, 1'b0, 1'b0);
    step();
    step();
    chk("pre_rst_busy", 32'(blink_busy), 1);
    chk("pre_rst_rgb", 32'(rgb_o), 32'h0BBA);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_sram_en", 32'(sram_bus.sram_en), 0);
    chk("mid_rst_sram_addr", 32'(sram_bus.sram_addr), 0);
    chk("mid_rst_rgb_o", 32'(rgb_o), 0);
    chk("mid_rst_rgb_valid", 32'(rgb_valid), 0);
    chk("mid_rst_sprite_hit", 32'(sprite_hit), 0);
    chk("mid_rst_blink_busy", 32'(blink_busy), 0);
    step();
    step();
    reset_n = 1'b1;
    repeat (4) step();
    chk("post_rst_busy", 32'(blink_busy), 0);
    chk("post_rst_rgb", 32'(rgb_o), 32'h0445);
    chk("post_rst_hit", 32'(sprite_hit), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
